// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered UART transmitter.
//   UART_ADDR            : store address the CPU decode maps onto this block
//   DEFAULT_CLKS_PER_BIT : 100 MHz / 115200 baud
//   uart_state_e         : serializer FSM encoding (2-bit)
package uart_tx_fifo_pkg;

  localparam logic [31:0] UART_ADDR            = 32'h8000_0000;
  localparam int          DEFAULT_CLKS_PER_BIT = 868;
  localparam int          DATA_BITS            = 8;

  typedef enum logic [1:0] {
    UART_S_IDLE  = 2'd0,
    UART_S_START = 2'd1,
    UART_S_DATA  = 2'd2,
    UART_S_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo_serializer.sv
// 8N1 frame serializer: FSM, baud counter and shift register.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : take data_in and start a frame (only honoured while ready)
//   data_in    : byte to transmit
//   ready      : a load is accepted this cycle (IDLE, or last cycle of STOP)
//   tx         : serial line, registered, idle high
//   busy       : FSM is not IDLE
module uart_tx_fifo_serializer
  import uart_tx_fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data_in,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  uart_state_e       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              baud_last;

  assign baud_last = (baud_q == BAUD_LAST);

  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BAUD_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    ready   = 1'b0;

    unique case (state_q)
      UART_S_IDLE: begin
        baud_d = '0;
        ready  = 1'b1;
        if (load) begin
          state_d = UART_S_START;
          shift_d = data_in;
        end
      end
      UART_S_START: begin
        if (baud_last) begin
          state_d = UART_S_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      UART_S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'(DATA_BITS - 1)) begin
            state_d = UART_S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
          end
        end
      end
      UART_S_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          ready  = 1'b1;
          // Back-to-back frames: a waiting byte goes straight to START.
          if (load) begin
            state_d = UART_S_START;
            shift_d = data_in;
          end else begin
            state_d = UART_S_IDLE;
          end
        end
      end
      default: state_d = UART_S_IDLE;
    endcase

    // Line level follows the state being entered, so it is ready at the
    // same edge as the state change and comes straight out of a flop.
    unique case (state_d)
      UART_S_START: tx_d = 1'b0;
      UART_S_DATA:  tx_d = shift_d[0];
      default:      tx_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops
  // update together; blocking is reserved for the combinational block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UART_S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != UART_S_IDLE);

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a FIFO absorbs CPU store bursts and feeds an
// 8N1 serializer.
// Ports:
//   sys_clk_i, sys_rstn_i : clock, asynchronous active-low reset
//   uart_wr_i, uart_dat_i : push strobe and byte
//   clr_ovf_i             : clears the sticky overflow flag
//   uart_tx               : serial line, idle high
//   full_o, empty_o       : FIFO full / empty
//   count_o               : bytes queued, excluding the one being shifted
//   busy_o                : serializer active
//   overflow_o            : sticky, a push was dropped
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic            sys_clk_i,
  input  logic            sys_rstn_i,
  input  logic            uart_wr_i,
  input  logic [7:0]      uart_dat_i,
  input  logic            clr_ovf_i,
  output logic            uart_tx,
  output logic            full_o,
  output logic            empty_o,
  output logic [ADDR_W:0] count_o,
  output logic            busy_o,
  output logic            overflow_o
);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wptr_q, rptr_q;
  logic [ADDR_W:0]   count_q;
  logic              overflow_q;
  logic              push, pop, ser_ready;

  // Full/empty come from the registered count, so a push into a full FIFO
  // is dropped even when a pop frees a slot on the same edge.
  assign full_o  = (count_q == (ADDR_W + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push    = uart_wr_i && !full_o;
  assign pop     = ser_ready && !empty_o;

  // NOTE: the storage array has no reset; emptiness is tracked by the
  // pointers and count, so stale contents are never read.
  always_ff @(posedge sys_clk_i) begin
    if (push) mem[wptr_q] <= uart_dat_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + ADDR_W'(1);
      if (pop)  rptr_q <= rptr_q + ADDR_W'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (ADDR_W + 1)'(1);
        2'b01:   count_q <= count_q - (ADDR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
      // A dropped push outranks a clear on the same edge.
      if (uart_wr_i && full_o) overflow_q <= 1'b1;
      else if (clr_ovf_i)      overflow_q <= 1'b0;
    end
  end

  uart_tx_fifo_serializer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_serializer (
    .clk     (sys_clk_i),
    .rst_n   (sys_rstn_i),
    .load    (pop),
    .data_in (mem[rptr_q]),
    .ready   (ser_ready),
    .tx      (uart_tx),
    .busy    (busy_o)
  );

  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLKS_PER_BIT=4, DEPTH=16.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int CPB    = 4;

  logic            sys_clk_i = 1'b0;
  logic            sys_rstn_i;
  logic            uart_wr_i;
  logic [7:0]      uart_dat_i;
  logic            clr_ovf_i;
  logic            uart_tx;
  logic            full_o;
  logic            empty_o;
  logic [ADDR_W:0] count_o;
  logic            busy_o;
  logic            overflow_o;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(
    .DEPTH        (DEPTH),
    .ADDR_W       (ADDR_W),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .sys_clk_i  (sys_clk_i),
    .sys_rstn_i (sys_rstn_i),
    .uart_wr_i  (uart_wr_i),
    .uart_dat_i (uart_dat_i),
    .clr_ovf_i  (clr_ovf_i),
    .uart_tx    (uart_tx),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .count_o    (count_o),
    .busy_o     (busy_o),
    .overflow_o (overflow_o)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on the falling edge holding the first start-bit sample; checks
  // every cycle of the 10-bit frame and returns on its last sample.
  task automatic rx_frame(input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < CPB; k++) begin
        if (i != 0 || k != 0) @(negedge sys_clk_i);
        check(uart_tx, frame[i], $sformatf("tx_byte%02h_bit%0d_cyc%0d", b, i, k));
      end
    end
  endtask

  // Bounded wait for the line to fall; an expired bound counts as a failure.
  task automatic wait_start(input int max_cycles);
    int n;
    n = 0;
    while (uart_tx !== 1'b0 && n < max_cycles) begin
      @(negedge sys_clk_i);
      n++;
    end
    check(uart_tx, 1'b0, "start_bit_timeout");
  endtask

  initial begin
    sys_rstn_i = 1'b0;
    uart_wr_i  = 1'b0;
    uart_dat_i = 8'h00;
    clr_ovf_i  = 1'b0;

    // ---- reset state ----
    repeat (3) @(negedge sys_clk_i);
    check(uart_tx, 1'b1, "rst_tx");
    check(count_o, 0, "rst_count");
    check(empty_o, 1'b1, "rst_empty");
    check(full_o, 1'b0, "rst_full");
    check(busy_o, 1'b0, "rst_busy");
    check(overflow_o, 1'b0, "rst_ovf");
    sys_rstn_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clk_i);
      check(uart_tx, 1'b1, "idle_tx");
    end
    check(busy_o, 1'b0, "idle_busy");

    // ---- single byte A5, exact latency ----
    uart_wr_i  = 1'b1;
    uart_dat_i = 8'hA5;
    @(negedge sys_clk_i);
    uart_wr_i = 1'b0;
    check(count_o, 1, "a5_count_after_push");
    check(empty_o, 1'b0, "a5_empty_after_push");
    check(uart_tx, 1'b1, "a5_tx_before_start");
    check(busy_o, 1'b0, "a5_busy_before_start");
    @(negedge sys_clk_i);
    check(busy_o, 1'b1, "a5_busy_at_start");
    check(count_o, 0, "a5_count_after_pop");
    rx_frame(8'hA5);
    @(negedge sys_clk_i);
    check(busy_o, 1'b0, "a5_busy_after_frame");
    check(uart_tx, 1'b1, "a5_tx_after_frame");

    // ---- burst of 3, back-to-back frames ----
    fork
      begin
        uart_wr_i  = 1'b1;
        uart_dat_i = 8'h41;
        @(negedge sys_clk_i);
        check(count_o, 1, "burst_count_1");
        uart_dat_i = 8'h42;
        @(negedge sys_clk_i);
        check(count_o, 1, "burst_count_pushpop");
        uart_dat_i = 8'h43;
        @(negedge sys_clk_i);
        uart_wr_i = 1'b0;
        check(count_o, 2, "burst_count_peak");
      end
      begin
        wait_start(10);
        rx_frame(8'h41);
        @(negedge sys_clk_i);
        rx_frame(8'h42);
        @(negedge sys_clk_i);
        rx_frame(8'h43);
        @(negedge sys_clk_i);
        check(busy_o, 1'b0, "burst_busy_end");
        check(empty_o, 1'b1, "burst_empty_end");
      end
    join

    // ---- overflow: 18 pushes, last one dropped with a coinciding clear ----
    fork
      begin
        for (int i = 0; i < 18; i++) begin
          uart_wr_i  = 1'b1;
          uart_dat_i = 8'(8'h10 + i);
          clr_ovf_i  = (i == 17);
          @(negedge sys_clk_i);
          if (i == 0) check(count_o, 1, "ovf_count_first");
          if (i == 16) begin
            check(count_o, 16, "ovf_count_full");
            check(full_o, 1'b1, "ovf_full");
            check(overflow_o, 1'b0, "ovf_not_yet");
          end
        end
        uart_wr_i = 1'b0;
        clr_ovf_i = 1'b0;
        check(overflow_o, 1'b1, "ovf_set_wins_over_clear");
        check(count_o, 16, "ovf_count_after_drop");
        check(full_o, 1'b1, "ovf_full_after_drop");
        @(negedge sys_clk_i);
        check(overflow_o, 1'b1, "ovf_sticky");
        clr_ovf_i = 1'b1;
        @(negedge sys_clk_i);
        clr_ovf_i = 1'b0;
        check(overflow_o, 1'b0, "ovf_cleared");
      end
      begin
        wait_start(10);
        for (int j = 0; j < 17; j++) begin
          if (j > 0) @(negedge sys_clk_i);
          rx_frame(8'(8'h10 + j));
        end
        @(negedge sys_clk_i);
        check(busy_o, 1'b0, "ovf_busy_end");
        check(count_o, 0, "ovf_count_end");
        check(empty_o, 1'b1, "ovf_empty_end");
      end
    join

    // ---- wrap-around: 8 groups of 5 ----
    for (int g = 0; g < 8; g++) begin
      automatic int base = g * 5;
      fork
        begin
          for (int i = 0; i < 5; i++) begin
            uart_wr_i  = 1'b1;
            uart_dat_i = 8'((base + i) * 7 + 3);
            @(negedge sys_clk_i);
          end
          uart_wr_i = 1'b0;
        end
        begin
          wait_start(10);
          for (int j = 0; j < 5; j++) begin
            if (j > 0) @(negedge sys_clk_i);
            rx_frame(8'((base + j) * 7 + 3));
          end
          @(negedge sys_clk_i);
        end
      join
      check(count_o, 0, $sformatf("wrap_count_g%0d", g));
      check(busy_o, 1'b0, $sformatf("wrap_busy_g%0d", g));
    end

    // ---- reset mid-frame during data bit 3 ----
    uart_wr_i  = 1'b1;
    uart_dat_i = 8'hC3;
    @(negedge sys_clk_i);
    uart_dat_i = 8'h3C;
    @(negedge sys_clk_i);
    uart_wr_i = 1'b0;
    check(uart_tx, 1'b0, "mid_start_bit");
    repeat (17) @(negedge sys_clk_i);
    check(uart_tx, 1'b0, "mid_data_bit3");
    check(count_o, 1, "mid_count_before_rst");
    #1 sys_rstn_i = 1'b0;
    #1;
    check(uart_tx, 1'b1, "mid_rst_tx_async");
    check(count_o, 0, "mid_rst_count");
    check(empty_o, 1'b1, "mid_rst_empty");
    check(busy_o, 1'b0, "mid_rst_busy");
    @(negedge sys_clk_i);
    sys_rstn_i = 1'b1;
    repeat (5) @(negedge sys_clk_i);
    check(uart_tx, 1'b1, "post_rst_idle_tx");
    check(empty_o, 1'b1, "post_rst_empty");
    uart_wr_i  = 1'b1;
    uart_dat_i = 8'h55;
    @(negedge sys_clk_i);
    uart_wr_i = 1'b0;
    check(count_o, 1, "post_rst_count");
    @(negedge sys_clk_i);
    rx_frame(8'h55);
    @(negedge sys_clk_i);
    check(busy_o, 1'b0, "post_rst_busy_end");
    check(empty_o, 1'b1, "post_rst_empty_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
